// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants, FSM state encoding and operand-sign helpers
// for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN       = 32;
  localparam int ITER_COUNT = 32;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } muldiv_state_e;

  function automatic logic rs1_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: EX-stage request/result bundle between the pipeline
// (master) and the multiply/divide unit (slave).
interface ex_muldiv_unit_if;
  import muldiv_pkg::*;

  logic            i_valid_e;
  logic            i_flush;
  logic [2:0]      i_f3_e;
  logic [XLEN-1:0] i_op_a_e;
  logic [XLEN-1:0] i_op_b_e;
  logic            o_stall;
  logic            o_done;
  logic [XLEN-1:0] o_result;
  logic            o_busy;

  modport master (
    output i_valid_e, i_flush, i_f3_e, i_op_a_e, i_op_b_e,
    input  o_stall, o_done, o_result, o_busy
  );

  modport slave (
    input  i_valid_e, i_flush, i_f3_e, i_op_a_e, i_op_b_e,
    output o_stall, o_done, o_result, o_busy
  );

endinterface

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: 64-bit accumulator with one radix-2 shift-add (multiply)
// or restoring shift-subtract (divide) step per enabled cycle; unsigned only.
module muldiv_iter_core
  import muldiv_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_is_div,
  input  logic [XLEN-1:0]   i_mag_a,
  input  logic [XLEN-1:0]   i_mag_b,
  output logic [2*XLEN-1:0] o_acc_step
);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     rem_shl;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_sub;

  // mul: acc = {partial product, remaining multiplier bits}, shifts right
  // div: acc = {partial remainder, dividend bits / quotient bits}, shifts left
  always_comb begin
    add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_shl = acc_q[2*XLEN-1:XLEN-1];
    rem_ge  = (rem_shl >= {1'b0, opnd_q});
    rem_sub = rem_shl[XLEN-1:0] - opnd_q;
    if (i_is_div) begin
      if (rem_ge) o_acc_step = {rem_sub, acc_q[XLEN-2:0], 1'b1};
      else        o_acc_step = {rem_shl[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      o_acc_step = {add_sum, acc_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else if (i_load) begin
      acc_q  <= {{XLEN{1'b0}}, i_mag_a};
      opnd_q <= i_mag_b;
    end else if (i_step) begin
      acc_q  <= o_acc_step;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide in EX, stalling IF/ID and ID/EX while busy.
// Build option MULDIV_FAST_MUL_EN: MUL* complete in one cycle; divides always iterate.
//
// state  | meaning
// S_IDLE | waiting for an M instruction in EX; special divides resolve here
// S_CALC | one radix-2 step per cycle, ITER_COUNT steps
// S_DONE | o_done pulse, result valid, pipeline advances
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic             i_clk,
  input logic             i_rst,
  ex_muldiv_unit_if.slave bus
);
  import muldiv_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_COUNT - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state_q, state_d;
  logic [2:0]        f3_q;
  logic              neg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   result_q, res_d;
  logic              cap_en, step_en, res_en, done_w;

  logic              sign_a, sign_b, neg_d;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_by_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;

  logic [2*XLEN-1:0] acc_step, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

  assign sign_a = rs1_signed(bus.i_f3_e) & bus.i_op_a_e[XLEN-1];
  assign sign_b = rs2_signed(bus.i_f3_e) & bus.i_op_b_e[XLEN-1];
  assign mag_a  = sign_a ? -bus.i_op_a_e : bus.i_op_a_e;
  assign mag_b  = sign_b ? -bus.i_op_b_e : bus.i_op_b_e;
  // remainder follows the dividend; products and quotients follow sign(a)^sign(b)
  assign neg_d  = (bus.i_f3_e[2] & bus.i_f3_e[1]) ? sign_a : (sign_a ^ sign_b);

  assign div_by_zero = (bus.i_op_b_e == '0);
  assign div_ovf     = ((bus.i_f3_e == F3_DIV) || (bus.i_f3_e == F3_REM)) &&
                       (bus.i_op_a_e == INT_MIN) && (bus.i_op_b_e == '1);
  assign special     = bus.i_f3_e[2] & (div_by_zero | div_ovf);
  assign special_res = div_by_zero ? (bus.i_f3_e[1] ? bus.i_op_a_e : '1)
                                   : (bus.i_f3_e[1] ? '0 : INT_MIN);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  logic [XLEN-1:0]   fast_res;

  assign fast_a    = {{XLEN{sign_a}}, bus.i_op_a_e};
  assign fast_b    = {{XLEN{sign_b}}, bus.i_op_b_e};
  assign fast_prod = fast_a * fast_b;
  assign fast_res  = (bus.i_f3_e == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

  muldiv_iter_core u_core (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (cap_en),
    .i_step     (step_en),
    .i_is_div   (f3_q[2]),
    .i_mag_a    (mag_a),
    .i_mag_b    (mag_b),
    .o_acc_step (acc_step)
  );

  assign prod_fix = neg_q ? -acc_step : acc_step;
  assign quo_fix  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
  assign rem_fix  = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];

  always_comb begin
    final_res = prod_fix[2*XLEN-1:XLEN];
    case (f3_q)
      F3_MUL:                       final_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              final_res = quo_fix;
      F3_REM, F3_REMU:              final_res = rem_fix;
      default:                      final_res = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    step_en = 1'b0;
    res_en  = 1'b0;
    res_d   = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_valid_e) begin
          cap_en = 1'b1;
          if (special) begin
            state_d = S_DONE;
            res_en  = 1'b1;
            res_d   = special_res;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!bus.i_f3_e[2]) begin
            state_d = S_DONE;
            res_en  = 1'b1;
            res_d   = fast_res;
`endif
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        step_en = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          res_en  = 1'b1;
          res_d   = final_res;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // flush wins over everything except reset, and leaves the result untouched
    if (bus.i_flush) begin
      state_d = S_IDLE;
      cap_en  = 1'b0;
      step_en = 1'b0;
      res_en  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (cap_en) begin
        f3_q  <= bus.i_f3_e;
        neg_q <= neg_d;
        cnt_q <= '0;
      end else if (step_en) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (res_en) result_q <= res_d;
    end
  end

  assign done_w       = (state_q == S_DONE) & ~bus.i_flush;
  assign bus.o_done   = done_w;
  assign bus.o_stall  = bus.i_valid_e & ~done_w;
  assign bus.o_busy   = (state_q == S_CALC);
  assign bus.o_result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed vectors with hand-computed results, latency,
// stall, flush, back-to-back and reset behaviour of ex_muldiv_unit.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;
  localparam int SPC_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   done_cyc = 0;
  bit   valid_drop_seen = 1'b0;

  ex_muldiv_unit_if bus();

  ex_muldiv_unit dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && bus.o_busy && !bus.i_valid_e) valid_drop_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one instruction and hold it until o_done; scramble operands after capture.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int k = 0;
    int stall_cyc = 0;
    bit seen = 1'b0;
    bus.i_valid_e = 1'b1;
    bus.i_f3_e    = f3;
    bus.i_op_a_e  = a;
    bus.i_op_b_e  = b;
    #1;
    while (!seen && k < 60) begin
      if (bus.o_done) seen = 1'b1;
      else begin
        if (bus.o_stall) stall_cyc++;
        @(posedge clk); #1;
        k++;
        bus.i_op_a_e = a ^ 32'hA5A5_5A5A;
        bus.i_op_b_e = b ^ 32'h0F0F_F0F0;
        bus.i_f3_e   = f3 ^ 3'd1;
        #1;
      end
    end
    chk({tag, ":done"}, 32'(seen), 32'd1);
    chk({tag, ":lat"}, 32'(k), 32'(exp_lat));
    chk({tag, ":res"}, bus.o_result, exp_res);
    chk({tag, ":stall_cycles"}, 32'(stall_cyc), 32'(exp_lat));
    chk({tag, ":stall_at_done"}, 32'(bus.o_stall), 32'd0);
    done_cyc = cyc;
    @(posedge clk); #1;
    bus.i_valid_e = 1'b0;
    #1;
    chk({tag, ":pulse"}, 32'(bus.o_done), 32'd0);
    chk({tag, ":held"}, bus.o_result, exp_res);
  endtask

  initial begin
    int d1;
    bit seen;
    bus.i_valid_e = 1'b0;
    bus.i_flush   = 1'b0;
    bus.i_f3_e    = 3'd0;
    bus.i_op_a_e  = '0;
    bus.i_op_b_e  = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst:done",   32'(bus.o_done),  32'd0);
    chk("rst:busy",   32'(bus.o_busy),  32'd0);
    chk("rst:stall",  32'(bus.o_stall), 32'd0);
    chk("rst:result", bus.o_result,     32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("mul_7_m3",     F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    run_op("mulh_min",     F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT);
    run_op("mulhu_min",    F3_MULHU,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT);
    run_op("mulhsu_m1_2",  F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_LAT);
    run_op("mulhu_max",    F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_op("mul_m1_m1",    F3_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         MUL_LAT);

    run_op("div_m7_2",     F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DIV_LAT);
    run_op("rem_m7_2",     F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DIV_LAT);
    run_op("divu_max_2",   F3_DIVU,   32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF, DIV_LAT);

    // flush in cycle 10 of a DIV
    bus.i_valid_e = 1'b1;
    bus.i_f3_e    = F3_DIV;
    bus.i_op_a_e  = 32'hFFFF_FFF9;
    bus.i_op_b_e  = 32'd2;
    repeat (10) begin @(posedge clk); #1; end
    #1;
    chk("flush:busy_before", 32'(bus.o_busy), 32'd1);
    bus.i_flush = 1'b1;
    @(posedge clk); #1;
    bus.i_flush   = 1'b0;
    bus.i_valid_e = 1'b0;
    #1;
    chk("flush:busy_after", 32'(bus.o_busy), 32'd0);
    chk("flush:result_kept", bus.o_result, 32'h7FFF_FFFF);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #2;
      if (bus.o_done) seen = 1'b1;
    end
    chk("flush:no_done", 32'(seen), 32'd0);

    // flush alongside a valid in IDLE must not start the (special) divide
    bus.i_valid_e = 1'b1;
    bus.i_flush   = 1'b1;
    bus.i_f3_e    = F3_DIVU;
    bus.i_op_a_e  = 32'd55;
    bus.i_op_b_e  = 32'd0;
    @(posedge clk); #1;
    bus.i_flush   = 1'b0;
    bus.i_valid_e = 1'b0;
    #1;
    chk("flush_idle:done", 32'(bus.o_done), 32'd0);
    chk("flush_idle:busy", 32'(bus.o_busy), 32'd0);

    run_op("divu_100_7",   F3_DIVU,   32'd100,        32'd7,         32'd14,        DIV_LAT);

    run_op("divu_x_0",     F3_DIVU,   32'd123,        32'd0,         32'hFFFF_FFFF, SPC_LAT);
    run_op("rem_13_0",     F3_REM,    32'd13,         32'd0,         32'd13,        SPC_LAT);
    run_op("div_ovf",      F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT);
    run_op("rem_ovf",      F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         SPC_LAT);

    // back-to-back: second instruction enters the cycle after the first o_done
    run_op("b2b_mul",      F3_MUL,    32'd3,          32'd5,         32'd15,        MUL_LAT);
    d1 = done_cyc;
    run_op("b2b_remu",     F3_REMU,   32'd100,        32'd7,         32'd2,         DIV_LAT);
    chk("b2b:gap", 32'(done_cyc - d1), 32'd34);

    // reset in the middle of a divide
    bus.i_valid_e = 1'b1;
    bus.i_f3_e    = F3_DIVU;
    bus.i_op_a_e  = 32'd1000;
    bus.i_op_b_e  = 32'd3;
    repeat (5) begin @(posedge clk); #1; end
    #1;
    chk("rst_mid:busy_before", 32'(bus.o_busy), 32'd1);
    rst = 1'b1;
    bus.i_valid_e = 1'b0;
    @(posedge clk); #2;
    chk("rst_mid:busy",   32'(bus.o_busy),  32'd0);
    chk("rst_mid:done",   32'(bus.o_done),  32'd0);
    chk("rst_mid:stall",  32'(bus.o_stall), 32'd0);
    chk("rst_mid:result", bus.o_result,     32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    chk("valid_held_in_calc", 32'(valid_drop_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
